// File: rtl/nanorv32_trace_buffer.sv
// rtl/nanorv32_trace_buffer.sv - in-order retirement trace buffer with load/store completion tracking
//
// Captures every retired instruction into a DEPTH-slot record FIFO. ALU records are complete
// on capture. Load/store records wait for their data-bus completion; the slot index is held
// in a pending queue of MAX_OUTSTANDING entries. Records leave strictly in program order on a
// valid/ready stream.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   ret_valid, ret_pc, ret_instr      retirement capture
//   ret_wr_en, ret_rd_idx, ret_rd_data
//   ret_kind, ret_addr                0=ALU, 1=load, 2=store, 3=treated as ALU
//   dbus_done, dbus_data              completion of the oldest outstanding transfer
//   out_valid, out_ready, out_*       head record stream
//   overflow, drop_cnt                sticky drop flag, saturating drop counter
//   protocol_err                      sticky: completion with nothing outstanding
module nanorv32_trace_buffer #(
    parameter int XLEN            = 32,
    parameter int INSTR_WIDTH     = 32,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TS_WIDTH        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ret_valid,
    input  logic [XLEN-1:0]        ret_pc,
    input  logic [INSTR_WIDTH-1:0] ret_instr,
    input  logic                   ret_wr_en,
    input  logic [4:0]             ret_rd_idx,
    input  logic [XLEN-1:0]        ret_rd_data,
    input  logic [1:0]             ret_kind,
    input  logic [XLEN-1:0]        ret_addr,
    input  logic                   dbus_done,
    input  logic [XLEN-1:0]        dbus_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   out_wr_en,
    output logic [4:0]             out_rd_idx,
    output logic [XLEN-1:0]        out_rd_data,
    output logic [1:0]             out_kind,
    output logic [XLEN-1:0]        out_addr,
    output logic [XLEN-1:0]        out_mem_data,
    output logic [TS_WIDTH-1:0]    out_ts,
    output logic                   overflow,
    output logic [TS_WIDTH-1:0]    drop_cnt,
    output logic                   protocol_err
);

    localparam int AW = $clog2(DEPTH);
    // Pending index width is at least 1 so MAX_OUTSTANDING=1 still has a legal slice;
    // the mask then pins the index to entry 0.
    localparam int PIW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int PMASK_I = MAX_OUTSTANDING - 1;
    localparam int PMAX_I  = MAX_OUTSTANDING;
    localparam logic [PIW-1:0] PMASK = PMASK_I[PIW-1:0];
    localparam logic [PIW:0]   PFULL = PMAX_I[PIW:0];

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;

    logic [XLEN-1:0]        s_pc      [DEPTH];
    logic [INSTR_WIDTH-1:0] s_instr   [DEPTH];
    logic                   s_wr_en   [DEPTH];
    logic [4:0]             s_rd_idx  [DEPTH];
    logic [XLEN-1:0]        s_rd_data [DEPTH];
    logic [1:0]             s_kind    [DEPTH];
    logic [XLEN-1:0]        s_addr    [DEPTH];
    logic [XLEN-1:0]        s_mem     [DEPTH];
    logic [TS_WIDTH-1:0]    s_ts      [DEPTH];
    logic                   s_done    [DEPTH];

    logic [AW-1:0]  pnd_q [2**PIW];

    logic [AW:0]    wptr, rptr;
    logic [PIW:0]   pnd_wptr, pnd_rptr;
    logic [TS_WIDTH-1:0] ts;

    logic [AW-1:0]  widx, ridx, cslot;
    logic [PIW-1:0] pnd_widx, pnd_ridx;
    logic [PIW:0]   pnd_cnt;
    logic           fifo_full, fifo_empty, pnd_full, pnd_empty;
    logic [1:0]     kind_n;
    logic           is_mem, accept, drop, complete, pop;

    assign widx       = wptr[AW-1:0];
    assign ridx       = rptr[AW-1:0];
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (widx == ridx);

    assign pnd_widx  = pnd_wptr[PIW-1:0] & PMASK;
    assign pnd_ridx  = pnd_rptr[PIW-1:0] & PMASK;
    assign pnd_cnt   = pnd_wptr - pnd_rptr;
    assign pnd_empty = (pnd_cnt == '0);
    assign pnd_full  = (pnd_cnt == PFULL);
    assign cslot     = pnd_q[pnd_ridx];

    assign kind_n   = (ret_kind == 2'd3) ? KIND_ALU : ret_kind;
    assign is_mem   = (kind_n != KIND_ALU);
    // Room is judged on registered state only; a same-cycle pop never frees space.
    assign accept   = ret_valid && !fifo_full && !(is_mem && pnd_full);
    assign drop     = ret_valid && !accept;
    // A completion can only target an entry pending before this cycle, so it can never
    // collide with the slot being written by a same-cycle retire.
    assign complete = dbus_done && !pnd_empty;

    assign out_valid = !fifo_empty && s_done[ridx];
    assign pop       = out_valid && out_ready;

    assign out_pc       = s_pc[ridx];
    assign out_instr    = s_instr[ridx];
    assign out_wr_en    = s_wr_en[ridx];
    assign out_rd_idx   = s_rd_idx[ridx];
    assign out_rd_data  = s_rd_data[ridx];
    assign out_kind     = s_kind[ridx];
    assign out_addr     = s_addr[ridx];
    assign out_mem_data = s_mem[ridx];
    assign out_ts       = s_ts[ridx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            pnd_wptr     <= '0;
            pnd_rptr     <= '0;
            ts           <= '0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
            protocol_err <= 1'b0;
            // Slot storage is cleared too so the muxed outputs read zero during reset.
            for (int i = 0; i < DEPTH; i++) begin
                s_pc[i]      <= '0;
                s_instr[i]   <= '0;
                s_wr_en[i]   <= 1'b0;
                s_rd_idx[i]  <= '0;
                s_rd_data[i] <= '0;
                s_kind[i]    <= '0;
                s_addr[i]    <= '0;
                s_mem[i]     <= '0;
                s_ts[i]      <= '0;
                s_done[i]    <= 1'b0;
            end
            for (int j = 0; j < 2**PIW; j++) begin
                pnd_q[j] <= '0;
            end
        end else begin
            ts <= ts + 1'b1;

            if (accept) begin
                s_pc[widx]      <= ret_pc;
                s_instr[widx]   <= ret_instr;
                s_wr_en[widx]   <= ret_wr_en;
                s_rd_idx[widx]  <= ret_rd_idx;
                s_rd_data[widx] <= ret_rd_data;
                s_kind[widx]    <= kind_n;
                s_addr[widx]    <= ret_addr;
                s_mem[widx]     <= '0;
                s_ts[widx]      <= ts;
                s_done[widx]    <= !is_mem;
                wptr            <= wptr + 1'b1;
                if (is_mem) begin
                    pnd_q[pnd_widx] <= widx;
                    pnd_wptr        <= pnd_wptr + 1'b1;
                end
            end

            if (complete) begin
                s_mem[cslot]  <= dbus_data;
                s_done[cslot] <= 1'b1;
                if (s_kind[cslot] == KIND_LOAD) begin
                    s_rd_data[cslot] <= dbus_data;
                end
                pnd_rptr <= pnd_rptr + 1'b1;
            end else if (dbus_done) begin
                protocol_err <= 1'b1;
            end

            if (pop) begin
                rptr <= rptr + 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nanorv32_trace_buffer.sv
// tb/tb_nanorv32_trace_buffer.sv - self-checking bench for nanorv32_trace_buffer
module tb_nanorv32_trace_buffer;

    localparam int DEPTH = 8;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = '0, ret_instr = '0, ret_rd_data = '0, ret_addr = '0;
    logic        ret_wr_en = 1'b0;
    logic [4:0]  ret_rd_idx = '0;
    logic [1:0]  ret_kind = '0;
    logic        dbus_done = 1'b0;
    logic [31:0] dbus_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_wr_en, overflow, protocol_err;
    logic [31:0] out_pc, out_instr, out_rd_data, out_addr, out_mem_data, out_ts, drop_cnt;
    logic [4:0]  out_rd_idx;
    logic [1:0]  out_kind;

    nanorv32_trace_buffer #(
        .XLEN(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .TS_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
        .ret_wr_en(ret_wr_en), .ret_rd_idx(ret_rd_idx), .ret_rd_data(ret_rd_data),
        .ret_kind(ret_kind), .ret_addr(ret_addr),
        .dbus_done(dbus_done), .dbus_data(dbus_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_wr_en(out_wr_en),
        .out_rd_idx(out_rd_idx), .out_rd_data(out_rd_data), .out_kind(out_kind),
        .out_addr(out_addr), .out_mem_data(out_mem_data), .out_ts(out_ts),
        .overflow(overflow), .drop_cnt(drop_cnt), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr, rd_data, addr, mem_data, ts;
        logic        wr_en;
        logic [4:0]  rd_idx;
        logic [1:0]  kind;
        bit          done;
        int          id;
    } rec_t;

    rec_t        mq[$];
    int          pq[$];
    logic [31:0] out_pcs[$];
    int          next_id;
    logic [31:0] m_ts, m_drop;
    bit          m_ovf, m_perr;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        pq.delete();
        out_pcs.delete();
        m_ts = '0;
        m_drop = '0;
        m_ovf = 1'b0;
        m_perr = 1'b0;
    endtask

    // Called at a negedge: drive, check the presented state, advance the model by one clock.
    task automatic cycle(input bit v, input logic [1:0] k, input logic [31:0] pc,
                         input logic [31:0] addr, input logic [31:0] rdd,
                         input bit done, input logic [31:0] ddata, input bit rdy);
        bit          exp_valid, acc;
        logic [1:0]  kn;
        rec_t        r;
        ret_valid   = v;
        ret_kind    = k;
        ret_pc      = pc;
        ret_addr    = addr;
        ret_rd_data = rdd;
        ret_instr   = $urandom;
        ret_wr_en   = 1'($urandom);
        ret_rd_idx  = 5'($urandom);
        dbus_done   = done;
        dbus_data   = ddata;
        out_ready   = rdy;
        #1;
        exp_valid = (mq.size() > 0) && mq[0].done;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("out_pc", 64'(out_pc), 64'(mq[0].pc));
            check("out_instr", 64'(out_instr), 64'(mq[0].instr));
            check("out_wr_en", 64'(out_wr_en), 64'(mq[0].wr_en));
            check("out_rd_idx", 64'(out_rd_idx), 64'(mq[0].rd_idx));
            check("out_rd_data", 64'(out_rd_data), 64'(mq[0].rd_data));
            check("out_kind", 64'(out_kind), 64'(mq[0].kind));
            check("out_addr", 64'(out_addr), 64'(mq[0].addr));
            check("out_mem_data", 64'(out_mem_data), 64'(mq[0].mem_data));
            check("out_ts", 64'(out_ts), 64'(mq[0].ts));
        end
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check("protocol_err", 64'(protocol_err), 64'(m_perr));

        kn  = (k == 2'd3) ? 2'd0 : k;
        acc = v && (mq.size() < DEPTH) && (kn == 2'd0 || pq.size() < MAXO);
        if (done) begin
            if (pq.size() > 0) begin
                int id = pq.pop_front();
                foreach (mq[i]) begin
                    if (mq[i].id == id) begin
                        mq[i].mem_data = ddata;
                        if (mq[i].kind == 2'd1) mq[i].rd_data = ddata;
                        mq[i].done = 1'b1;
                    end
                end
            end else begin
                m_perr = 1'b1;
            end
        end
        if (exp_valid && rdy) begin
            out_pcs.push_back(mq[0].pc);
            void'(mq.pop_front());
        end
        if (acc) begin
            r.pc = pc; r.instr = ret_instr; r.wr_en = ret_wr_en; r.rd_idx = ret_rd_idx;
            r.rd_data = rdd; r.kind = kn; r.addr = addr; r.mem_data = '0; r.ts = m_ts;
            r.done = (kn == 2'd0); r.id = next_id++;
            mq.push_back(r);
            if (kn != 2'd0) pq.push_back(r.id);
        end else if (v) begin
            m_ovf = 1'b1;
            if (m_drop != '1) m_drop++;
        end
        m_ts++;
        @(negedge clk);
    endtask

    task automatic ret(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] rdd, input bit rdy);
        cycle(1'b1, k, pc, addr, rdd, 1'b0, '0, rdy);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 2'd0, '0, '0, '0, 1'b0, '0, rdy);
    endtask

    task automatic complete(input logic [31:0] d, input bit rdy);
        cycle(1'b0, 2'd0, '0, '0, '0, 1'b1, d, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ret_valid = 1'b0;
        dbus_done = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_rd_data", 64'(out_rd_data), 64'd0);
        check("rst_out_ts", 64'(out_ts), 64'd0);
        check("rst_out_mem_data", 64'(out_mem_data), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_protocol_err", 64'(protocol_err), 64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        next_id = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        // ALU retire visible next cycle
        ret(2'd0, 32'h100, '0, 32'hCAFFE000, 1'b1);
        idle(1'b1);
        check("alu_emitted", 64'(out_pcs.size()), 64'd1);
        if (out_pcs.size() > 0) check("alu_pc", 64'(out_pcs[0]), 64'h100);

        // load at head blocks two younger ALU records
        out_pcs.delete();
        ret(2'd1, 32'h200, 32'h8000_0000, 32'hDEAD, 1'b1);
        ret(2'd0, 32'h204, '0, 32'h11, 1'b1);
        ret(2'd0, 32'h208, '0, 32'h22, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("load_blocked", 64'(out_pcs.size()), 64'd0);
        complete(32'h1234, 1'b1);
        repeat (4) idle(1'b1);
        check("load_order_n", 64'(out_pcs.size()), 64'd3);
        if (out_pcs.size() == 3) begin
            check("load_order0", 64'(out_pcs[0]), 64'h200);
            check("load_order1", 64'(out_pcs[1]), 64'h204);
            check("load_order2", 64'(out_pcs[2]), 64'h208);
        end

        // FIFO overflow with consumer stalled
        out_pcs.delete();
        for (int i = 0; i < 9; i++) ret(2'd0, 32'h300 + 32'(4 * i), '0, 32'(i), 1'b0);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drops", 64'(drop_cnt), 64'd1);
        repeat (10) idle(1'b1);
        check("ovf_emitted", 64'(out_pcs.size()), 64'd8);
        if (out_pcs.size() == 8) check("ovf_last", 64'(out_pcs[7]), 64'h31C);

        // pending queue full drops the third store
        do_reset();
        for (int i = 0; i < 3; i++) ret(2'd2, 32'h400 + 32'(4 * i), 32'h1000, '0, 1'b1);
        check("st_drops", 64'(drop_cnt), 64'd1);
        complete(32'hA, 1'b1);
        complete(32'hB, 1'b1);
        repeat (3) idle(1'b1);
        check("st_emitted", 64'(out_pcs.size()), 64'd2);

        // completion with nothing outstanding
        do_reset();
        complete(32'h77, 1'b1);
        idle(1'b1);
        check("perr_set", 64'(protocol_err), 64'd1);
        check("perr_no_rec", 64'(out_pcs.size()), 64'd0);

        // same-cycle load retire and completion from empty
        do_reset();
        cycle(1'b1, 2'd1, 32'h500, 32'h2000, '0, 1'b1, 32'h99, 1'b1);
        repeat (2) idle(1'b1);
        check("same_perr", 64'(protocol_err), 64'd1);
        check("same_pending", 64'(out_pcs.size()), 64'd0);
        complete(32'h55, 1'b1);
        idle(1'b1);
        check("same_done", 64'(out_pcs.size()), 64'd1);

        // reset mid-operation
        for (int i = 0; i < 4; i++) ret(2'd0, 32'h600 + 32'(4 * i), '0, 32'(i), 1'b0);
        do_reset();
        ret(2'd0, 32'h900, '0, 32'h5, 1'b1);
        idle(1'b1);
        check("post_rst_n", 64'(out_pcs.size()), 64'd1);
        if (out_pcs.size() > 0) check("post_rst_pc", 64'(out_pcs[0]), 64'h900);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, 2'($urandom), $urandom, $urandom, $urandom,
                  ($urandom % 3) == 0, $urandom, ($urandom % 4) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/nanorv32_trace_buffer.md
# nanorv32_trace_buffer

Parametrised retirement-trace buffer for the nanorv32 simulation and debug environment. It captures every retired instruction and holds loads and stores until their data-bus transfer completes. It then emits complete trace records strictly in program order over a valid/ready stream. It supports configurable depth, outstanding-access count and timestamp width. Overflow and protocol errors are reported explicitly rather than silently corrupting the trace.

## Interface
Parameters:
- XLEN, 32, data/address width
- INSTR_WIDTH, 32, captured instruction width
- DEPTH, 8, record slots; power of 2, ≥2
- MAX_OUTSTANDING, 2, pending load/store records; power of 2, ≤DEPTH
- TS_WIDTH, 32, timestamp and drop-counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ret_valid  in  1  instruction retired this cycle
- ret_pc  in  XLEN  PC of retired instruction
- ret_instr  in  INSTR_WIDTH  instruction word
- ret_wr_en  in  1  instruction writes rd
- ret_rd_idx  in  5  destination register
- ret_rd_data  in  XLEN  rd write value (ignored for loads)
- ret_kind  in  2  0=ALU/other, 1=load, 2=store, 3=reserved (treated as 0)
- ret_addr  in  XLEN  data address (load/store)
- dbus_done  in  1  oldest outstanding data transfer completes
- dbus_data  in  XLEN  read data (load) or write data (store) at completion
- out_valid  out  1  head record complete and presented
- out_ready  in  1  consumer accepts
- out_pc, out_instr, out_wr_en, out_rd_idx, out_rd_data, out_kind, out_addr  out  as ret_*  record fields
- out_mem_data  out  XLEN  dbus_data captured for load/store, 0 otherwise
- out_ts  out  TS_WIDTH  timestamp at retire
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  TS_WIDTH  dropped records, saturating
- protocol_err  out  1  sticky: dbus_done with nothing outstanding

## Operation
- Free-running timestamp counter. It resets to 0, increments every cycle and wraps modulo 2^TS_WIDTH. A record's ts is the counter value in its retire cycle.
- Record FIFO: DEPTH slots, each with a done flag. On accepted retire, write at the tail. done=1 if kind is ALU; done=0 if load/store.
- Load/store records also push their slot index into the pending queue (depth MAX_OUTSTANDING).
- On dbus_done with the pending queue non-empty:
  - pop the oldest index;
  - write dbus_data into that slot's mem_data;
  - for a load, also write it into rd_data;
  - set done.
- Acceptance of a retire uses registered state at the start of the cycle. A record is dropped if the FIFO is full, or if it is a load/store and the pending queue is full. A same-cycle pop does not create room.
- On a drop: no write, overflow←1, drop_cnt increments (saturating at all-ones).
- out_valid = FIFO non-empty and head done. The head pops on out_valid & out_ready. Records are never reordered: a pending head blocks younger completed records.
- dbus_done with an empty pending queue (registered state) sets protocol_err and is otherwise ignored.
- A retire and a dbus_done in the same cycle: the completion applies to the oldest previously pending entry, never to the same-cycle retire.
- Reset mid-operation discards all records and pending entries immediately.

## Timing
- Reset values:
  - out_valid, overflow, protocol_err, drop_cnt, ts counter: 0.
  - All out_* data fields: 0.
  - FIFO and pending queue: empty.
- Output fields are driven from registered slot storage, combinationally muxed by the head pointer. Fields are stable while out_valid & !out_ready.
- ALU retire into an empty FIFO: out_valid in the next cycle.
- Load/store: out_valid in the cycle after the dbus_done that completes it, provided it is at the head.
- Sustained throughput: one record per cycle in and one out. Simultaneous push and pop at full-1 and empty boundaries are legal.
- Pointers wrap modulo DEPTH and MAX_OUTSTANDING. An extra wrap bit distinguishes full from empty.

## Test plan
- Reset, then ALU retire pc=0x100, rd=x10, data=0xCAFFE000, out_ready=1 → out_valid one cycle later with those fields, out_kind=0, out_ts=1 cycle after retire count, out_mem_data=0.
- Load pc=0x200 addr=0x8000_0000, then two ALU retires, dbus_done 5 cycles later with data=0x1234 → nothing emitted until the cycle after dbus_done. Then load (rd_data=mem_data=0x1234) and the two ALUs are emitted in order.
- out_ready=0, 9 ALU retires with DEPTH=8 → 8 stored, overflow=1, drop_cnt=1. Releasing out_ready yields exactly 8 records in order.
- Three stores back-to-back with MAX_OUTSTANDING=2 → third dropped, drop_cnt=1. Two dbus_done with 0xA, 0xB → stores emitted with out_mem_data 0xA then 0xB.
- dbus_done with nothing pending → protocol_err=1, no record emitted. A load retire and a dbus_done in the same cycle from empty → protocol_err=1 and the load remains pending.
- Assert rst_n low with 4 records queued → all outputs 0 immediately. After release, a new ALU retire is the first record emitted.
